// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU writeback requests and registered CDB slots
// master: FU/regfile side, slave: the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32
);
  logic [NUM_REQ-1:0]                fu_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]     fu_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0]    fu_data;
  logic [NUM_REQ-1:0]                fu_ready;
  logic [NUM_PORTS-1:0]              cdb_valid;
  logic [NUM_PORTS-1:0][TAG_W-1:0]   cdb_tag;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  cdb_data;

  modport master (
    output fu_valid, fu_tag, fu_data,
    input  fu_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  fu_valid, fu_tag, fu_data,
    output fu_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin grant of FU results onto registered CDB slots
// Optional statistics counters enabled by CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  cdb_arbiter_if.slave       bus,
  output logic [31:0]        grant_count_o,
  output logic [31:0]        stall_cycles_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_PORTS + 1);

  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                 idx, last_idx;
  logic [CNT_W-1:0]                 n_grant;
  logic [NUM_REQ-1:0]               grant;
  logic [NUM_PORTS-1:0]             slot_valid_d, cdb_valid_q;
  logic [NUM_PORTS-1:0][TAG_W-1:0]  slot_tag_d, cdb_tag_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] slot_data_d, cdb_data_q;
  logic                             dup_tag;

  // Walk from rr_ptr with wraparound; the k-th winner lands in slot k.
  always_comb begin
    grant        = '0;
    slot_valid_d = '0;
    slot_tag_d   = '0;
    slot_data_d  = '0;
    n_grant      = '0;
    idx          = rr_ptr_q;
    last_idx     = rr_ptr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (bus.fu_valid[idx] && (n_grant < CNT_W'(NUM_PORTS))) begin
        grant[idx] = 1'b1;
        if (bus.fu_tag[idx] != '0) begin
          slot_valid_d[n_grant] = 1'b1;
          slot_tag_d[n_grant]   = bus.fu_tag[idx];
          slot_data_d[n_grant]  = bus.fu_data[idx];
        end
        last_idx = idx;
        n_grant  = n_grant + 1'b1;
      end
      idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
    if (reset_i) grant = '0;
    rr_ptr_d = rr_ptr_q;
    if (n_grant != '0)
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
  end

  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int j = i + 1; j < NUM_REQ; j++)
        if (grant[i] && grant[j] && (bus.fu_tag[i] != '0) && (bus.fu_tag[i] == bus.fu_tag[j]))
          dup_tag = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= slot_valid_d;
      cdb_tag_q   <= slot_tag_d;
      cdb_data_q  <= slot_data_d;
      assert (!dup_tag) else $error("cdb_arbiter: duplicate nonzero tag granted in one cycle");
    end
  end

  assign bus.fu_ready  = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] grant_count_q, stall_cycles_q;
  logic [32:0] grant_sum;
  logic        stall;

  assign grant_sum = {1'b0, grant_count_q} + 33'(n_grant);
  assign stall     = |(bus.fu_valid & ~grant);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      grant_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      grant_count_q <= grant_sum[32] ? 32'hFFFF_FFFF : grant_sum[31:0];
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign grant_count_o  = grant_count_q;
  assign stall_cycles_o = stall_cycles_q;
`else
  assign grant_count_o  = 32'h0;
  assign stall_cycles_o = 32'h0;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] grant_count, stall_cycles;
  int          n_assert = 0;
  int          n_fail   = 0;

`ifdef CDB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  cdb_arbiter_if #(.NUM_REQ(4), .NUM_PORTS(2), .TAG_W(6), .DATA_W(32)) bus ();

  cdb_arbiter #(.NUM_REQ(4), .NUM_PORTS(2), .TAG_W(6), .DATA_W(32)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .bus            (bus),
    .grant_count_o  (grant_count),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] gc, input logic [31:0] sc);
    chk({tag, "_gc"}, 64'(grant_count), 64'(STATS ? gc : 32'h0));
    chk({tag, "_sc"}, 64'(stall_cycles), 64'(STATS ? sc : 32'h0));
  endtask

  task automatic default_reqs();
    for (int i = 0; i < 4; i++) begin
      bus.fu_tag[i]  = 6'(i + 1);
      bus.fu_data[i] = 32'h100 + 32'(i);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.fu_valid = 4'b1111;
    default_reqs();

    // Reset held with all requesters valid
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", 64'(bus.fu_ready), 64'(4'b0000));
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'(2'b00));
    end
    chk_stats("rst", 32'd0, 32'd0);

    // Round-robin with all four valid
    rst = 1'b0;
    #1;
    chk("rr0_ready", 64'(bus.fu_ready), 64'(4'b0011));
    tick();
    chk("rr1_cdb_valid", 64'(bus.cdb_valid), 64'(2'b11));
    chk("rr1_tag0", 64'(bus.cdb_tag[0]), 64'd1);
    chk("rr1_tag1", 64'(bus.cdb_tag[1]), 64'd2);
    chk("rr1_data1", 64'(bus.cdb_data[1]), 64'h101);
    chk("rr1_ready", 64'(bus.fu_ready), 64'(4'b1100));
    chk_stats("rr1", 32'd2, 32'd1);
    tick();
    chk("rr2_tag0", 64'(bus.cdb_tag[0]), 64'd3);
    chk("rr2_tag1", 64'(bus.cdb_tag[1]), 64'd4);
    chk("rr2_ready", 64'(bus.fu_ready), 64'(4'b0011));
    chk_stats("rr2", 32'd4, 32'd2);
    tick();
    chk("rr3_tag0", 64'(bus.cdb_tag[0]), 64'd1);
    chk_stats("rr3", 32'd6, 32'd3);
    bus.fu_valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(bus.fu_ready), 64'(4'b0000));
    tick();
    chk("idle_cdb_valid", 64'(bus.cdb_valid), 64'(2'b00));

    // Latency: single request from requester 2 (rr_ptr=2)
    bus.fu_valid   = 4'b0100;
    bus.fu_tag[2]  = 6'd7;
    bus.fu_data[2] = 32'hDEAD;
    #1;
    chk("lat_ready", 64'(bus.fu_ready), 64'(4'b0100));
    tick();
    bus.fu_valid = 4'b0000;
    chk("lat_cdb_valid", 64'(bus.cdb_valid), 64'(2'b01));
    chk("lat_tag0", 64'(bus.cdb_tag[0]), 64'd7);
    chk("lat_data0", 64'(bus.cdb_data[0]), 64'hDEAD);
    chk("lat_tag1", 64'(bus.cdb_tag[1]), 64'd0);
    tick();
    chk("lat2_cdb_valid", 64'(bus.cdb_valid), 64'(2'b00));
    chk_stats("lat", 32'd7, 32'd3);

    // Wrap: rr_ptr=3, requesters 3 and 0
    default_reqs();
    bus.fu_tag[3] = 6'd9;
    bus.fu_tag[0] = 6'd10;
    bus.fu_valid  = 4'b1001;
    #1;
    chk("wrap_ready", 64'(bus.fu_ready), 64'(4'b1001));
    tick();
    chk("wrap_cdb_valid", 64'(bus.cdb_valid), 64'(2'b11));
    chk("wrap_slot0", 64'(bus.cdb_tag[0]), 64'd9);
    chk("wrap_slot1", 64'(bus.cdb_tag[1]), 64'd10);
    default_reqs();
    bus.fu_valid = 4'b1111;
    #1;
    chk("wrap_next_ptr", 64'(bus.fu_ready), 64'(4'b0110));
    tick();
    chk("wrap2_tag0", 64'(bus.cdb_tag[0]), 64'd2);
    chk("wrap2_tag1", 64'(bus.cdb_tag[1]), 64'd3);
    chk_stats("wrap", 32'd11, 32'd4);
    bus.fu_valid = 4'b0000;
    tick();

    // Tag 0 consumes slot 0 but does not write (rr_ptr=3)
    bus.fu_tag[0]  = 6'd0;
    bus.fu_data[0] = 32'h77;
    bus.fu_tag[1]  = 6'd5;
    bus.fu_data[1] = 32'h55;
    bus.fu_valid   = 4'b0011;
    #1;
    chk("tag0_ready", 64'(bus.fu_ready), 64'(4'b0011));
    tick();
    bus.fu_valid = 4'b0000;
    chk("tag0_cdb_valid", 64'(bus.cdb_valid), 64'(2'b10));
    chk("tag0_tag0", 64'(bus.cdb_tag[0]), 64'd0);
    chk("tag0_data0", 64'(bus.cdb_data[0]), 64'd0);
    chk("tag0_tag1", 64'(bus.cdb_tag[1]), 64'd5);
    chk("tag0_data1", 64'(bus.cdb_data[1]), 64'h55);
    chk_stats("tag0", 32'd13, 32'd4);

    // Reset mid-operation while requests are pending (rr_ptr=2)
    default_reqs();
    bus.fu_valid = 4'b1111;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(bus.fu_ready), 64'(4'b0000));
    tick();
    chk("midrst_cdb_valid", 64'(bus.cdb_valid), 64'(2'b00));
    chk_stats("midrst", 32'd0, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ptr", 64'(bus.fu_ready), 64'(4'b0011));
    bus.fu_valid = 4'b0000;
    tick();

    // Saturation of grant_count (rr_ptr=0)
`ifdef CDB_ARB_STATS_EN
    force dut.grant_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.grant_count_q;
    #1;
    chk("sat_forced", 64'(grant_count), 64'h0000_0000_FFFF_FFFE);
`endif
    bus.fu_valid = 4'b0011;
    tick();
    chk_stats("sat1", 32'hFFFF_FFFF, 32'd0);
    bus.fu_valid = 4'b1100;
    #1;
    chk("sat_ready", 64'(bus.fu_ready), 64'(4'b1100));
    tick();
    bus.fu_valid = 4'b0000;
    chk_stats("sat2", 32'hFFFF_FFFF, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
